// File: rtl/onehot_fsm_seq_if.sv
// onehot_fsm_seq_if: control and status bundle for the one-hot sequencer.
// Master drives the step controls, slave returns state and flags.
interface onehot_fsm_seq_if #(
  parameter int NUM_STATES = 4,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = $clog2(NUM_STATES)
);
  logic                  en_i;
  logic [NUM_STATES-1:0] adv_i;
  logic                  abort_i;
  logic [CNT_W-1:0]      timeout_lim_i;
  logic                  err_clr_i;
  logic [NUM_STATES-1:0] state_o;
  logic [IDX_W-1:0]      state_idx_o;
  logic                  wrap_pulse_o;
  logic                  timeout_err_o;
  logic                  illegal_err_o;

  modport master (
    output en_i, adv_i, abort_i,
    output timeout_lim_i, err_clr_i,
    input  state_o, state_idx_o,
    input  wrap_pulse_o, timeout_err_o,
    input  illegal_err_o
  );

  modport slave (
    input  en_i, adv_i, abort_i,
    input  timeout_lim_i, err_clr_i,
    output state_o, state_idx_o,
    output wrap_pulse_o, timeout_err_o,
    output illegal_err_o
  );
endinterface

// File: rtl/onehot_fsm_seq.sv
// onehot_fsm_seq: N-state registered one-hot sequencer with
// fallback, dwell watchdog, abort and illegal-encoding recovery.
module onehot_fsm_seq #(
  parameter int NUM_STATES = 4,
  parameter int CNT_W      = 8,
  parameter logic [NUM_STATES-1:0] FALLBACK_MASK = 4'b0010,
  parameter int IDX_W      = $clog2(NUM_STATES)
) (
  input logic clk,
  input logic rst_n,
  onehot_fsm_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ACT_ILLEGAL,
    ACT_ABORT,
    ACT_HOLD,
    ACT_TMO,
    ACT_ADV,
    ACT_FALL,
    ACT_STAY
  } act_e;

  localparam logic [NUM_STATES-1:0] IDLE =
    NUM_STATES'(1);
  localparam logic [NUM_STATES-1:0] FB_MASK =
    {FALLBACK_MASK[NUM_STATES-1:1], 1'b0};

  logic [NUM_STATES-1:0] state_q, state_d;
  logic [CNT_W-1:0]      dwell_q, dwell_d;
  logic                  wrap_q, wrap_d;
  logic                  tmo_q, tmo_d;
  logic                  ill_q, ill_d;

  logic                  legal;
  logic                  is_idle;
  logic                  cur_adv;
  logic                  cur_fb;
  logic                  tmo_hit;
  logic [NUM_STATES-1:0] rot;
  logic [IDX_W-1:0]      idx;
  act_e                  act;

  assign legal   = (|state_q) &&
                   ((state_q & (state_q - 1'b1)) == '0);
  assign is_idle = state_q[0];
  assign cur_adv = |(bus.adv_i & state_q);
  assign cur_fb  = |(~bus.adv_i & state_q & FB_MASK);
  assign tmo_hit = !is_idle &&
                   (bus.timeout_lim_i != '0) &&
                   (dwell_q == bus.timeout_lim_i);
  assign rot     = {state_q[NUM_STATES-2:0],
                    state_q[NUM_STATES-1]};

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (state_q[i]) idx = idx | IDX_W'(i);
    end
    if (!legal) idx = '0;
  end

  always_comb begin
    if (!legal)                act = ACT_ILLEGAL;
    else if (bus.abort_i)      act = ACT_ABORT;
    else if (!bus.en_i)        act = ACT_HOLD;
    else if (tmo_hit)          act = ACT_TMO;
    else if (cur_adv)          act = ACT_ADV;
    else if (cur_fb)           act = ACT_FALL;
    else                       act = ACT_STAY;
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    tmo_d   = 1'b0;
    ill_d   = ill_q & ~bus.err_clr_i;
    unique case (act)
      ACT_ILLEGAL: begin
        state_d = IDLE;
        dwell_d = '0;
        ill_d   = 1'b1;
      end
      ACT_ABORT, ACT_FALL: begin
        state_d = IDLE;
        dwell_d = '0;
      end
      ACT_HOLD: ;
      ACT_TMO: begin
        state_d = IDLE;
        dwell_d = '0;
        tmo_d   = 1'b1;
      end
      ACT_ADV: begin
        state_d = rot;
        dwell_d = '0;
        wrap_d  = state_q[NUM_STATES-1];
      end
      ACT_STAY: begin
        // IDLE keeps the counter pinned at zero
        if (is_idle)              dwell_d = '0;
        else if (dwell_q != '1)   dwell_d = dwell_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
      tmo_q   <= tmo_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.state_o       = state_q;
  assign bus.state_idx_o   = idx;
  assign bus.wrap_pulse_o  = wrap_q;
  assign bus.timeout_err_o = tmo_q;
  assign bus.illegal_err_o = ill_q;

endmodule

// File: tb/tb_onehot_fsm_seq.sv
// tb_onehot_fsm_seq: directed vectors with a queued scoreboard;
// the monitor pops one expectation per clock edge.
module tb_onehot_fsm_seq;

  logic clk;
  logic rst_n;

  onehot_fsm_seq_if #(.NUM_STATES(4), .CNT_W(8)) bus ();

  onehot_fsm_seq #(
    .NUM_STATES(4),
    .CNT_W(8),
    .FALLBACK_MASK(4'b0010)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] st;
    logic       w;
    logic       t;
    logic       i;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(logic [3:0] s);
    case (s)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    logic [1:0] wi;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        wi = idx_of(e.st);
        n_tests++;
        if (bus.state_o !== e.st || bus.state_idx_o !== wi ||
            bus.wrap_pulse_o !== e.w ||
            bus.timeout_err_o !== e.t ||
            bus.illegal_err_o !== e.i) begin
          n_fail++;
          $display("FAIL %s: got st=%b idx=%0d w=%b t=%b i=%b want st=%b idx=%0d w=%b t=%b i=%b",
                   e.nm, bus.state_o, bus.state_idx_o,
                   bus.wrap_pulse_o, bus.timeout_err_o,
                   bus.illegal_err_o, e.st, wi, e.w, e.t, e.i);
        end
      end
    end
  end

  task automatic step(logic en, logic [3:0] adv, logic ab,
                      logic [7:0] lim, logic clr,
                      logic [3:0] st, logic w, logic t,
                      logic i, string nm);
    exp_t e;
    @(negedge clk);
    bus.en_i          = en;
    bus.adv_i         = adv;
    bus.abort_i       = ab;
    bus.timeout_lim_i = lim;
    bus.err_clr_i     = clr;
    e.st = st; e.w = w; e.t = t; e.i = i; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.en_i          = 1'b0;
    bus.adv_i         = '0;
    bus.abort_i       = 1'b0;
    bus.timeout_lim_i = '0;
    bus.err_clr_i     = 1'b0;
    #12;
    chk("reset_state", 32'(bus.state_o), 32'h1);
    chk("reset_flags", {bus.wrap_pulse_o, bus.timeout_err_o,
                        bus.illegal_err_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 4'b0001, 0, 0, 0, 4'b0010, 0, 0, 0, "adv0");
    step(1, 4'b0000, 0, 0, 0, 4'b0001, 0, 0, 0, "fallback1");
    step(1, 4'b0001, 0, 0, 0, 4'b0010, 0, 0, 0, "walk1");
    step(1, 4'b0010, 0, 0, 0, 4'b0100, 0, 0, 0, "walk2");
    step(1, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 0, "hold2a");
    step(1, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 0, "hold2b");
    @(posedge clk); #2;
    chk("dwell_inc", 32'(dut.dwell_q), 32'd2);
    step(1, 4'b0100, 0, 0, 0, 4'b1000, 0, 0, 0, "walk3");
    step(1, 4'b1000, 0, 0, 0, 4'b0001, 1, 0, 0, "wrap");
    step(1, 4'b0000, 0, 0, 0, 4'b0001, 0, 0, 0, "wrap_clr");

    step(1, 4'b0001, 0, 3, 0, 4'b0010, 0, 0, 0, "to_s1");
    step(1, 4'b0010, 0, 3, 0, 4'b0100, 0, 0, 0, "to_s2");
    step(1, 4'b0000, 0, 3, 0, 4'b0100, 0, 0, 0, "tmo_d1");
    step(1, 4'b0000, 0, 3, 0, 4'b0100, 0, 0, 0, "tmo_d2");
    step(1, 4'b0000, 0, 3, 0, 4'b0100, 0, 0, 0, "tmo_d3");
    step(1, 4'b0000, 0, 3, 0, 4'b0001, 0, 1, 0, "tmo_fire");
    step(1, 4'b0000, 0, 3, 0, 4'b0001, 0, 0, 0, "tmo_clr");

    step(1, 4'b0001, 0, 0, 0, 4'b0010, 0, 0, 0, "sat_s1");
    step(1, 4'b0010, 0, 0, 0, 4'b0100, 0, 0, 0, "sat_s2");
    for (int k = 0; k < 300; k++)
      step(1, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 0, "no_tmo");
    @(posedge clk); #2;
    chk("dwell_sat", 32'(dut.dwell_q), 32'd255);
    step(0, 4'b0100, 0, 0, 0, 4'b0100, 0, 0, 0, "en_hold");
    step(0, 4'b0000, 1, 0, 0, 4'b0001, 0, 0, 0, "abort_en0");

    step(1, 4'b0000, 0, 0, 0, 4'b0001, 0, 0, 1, "ill_0110");
    force dut.state_q = 4'b0110;
    #1;
    chk("ill_idx_0110", 32'(bus.state_idx_o), 0);
    release dut.state_q;
    step(1, 4'b0000, 0, 0, 0, 4'b0001, 0, 0, 1, "ill_sticky");
    step(1, 4'b0000, 0, 0, 1, 4'b0001, 0, 0, 1, "ill_0000_clr");
    force dut.state_q = 4'b0000;
    #1;
    chk("ill_idx_0000", 32'(bus.state_idx_o), 0);
    release dut.state_q;
    step(1, 4'b0000, 0, 0, 1, 4'b0001, 0, 0, 0, "ill_clr");
    step(1, 4'b0000, 0, 0, 0, 4'b0001, 0, 0, 0, "ill_stay0");

    step(1, 4'b0001, 0, 0, 0, 4'b0010, 0, 0, 0, "r_s1");
    step(1, 4'b0010, 0, 0, 0, 4'b0100, 0, 0, 0, "r_s2");
    step(1, 4'b0100, 0, 0, 0, 4'b1000, 0, 0, 0, "r_s3");
    @(negedge clk);
    bus.adv_i = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus.state_o), 32'h1);
    chk("async_rst_flags", {bus.wrap_pulse_o,
                            bus.timeout_err_o,
                            bus.illegal_err_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'b0001, 0, 0, 0, 4'b0010, 0, 0, 0, "post_rst");

    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d left want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
